// File: rtl/palette_lut.sv
// palette_lut: runtime-writable multi-channel colour palette with transparency key and brightness fade
module palette_lut #(
    parameter int INDEX_W   = 4,
    parameter int NUM_CH    = 2,
    parameter int COLOR_W   = 4,
    parameter int KEY_INDEX = 5
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         wr_en,
    input  logic [INDEX_W-1:0]           wr_index,
    input  logic [3*COLOR_W-1:0]         wr_rgb,
    input  logic [NUM_CH-1:0]            rd_req,
    input  logic [NUM_CH*INDEX_W-1:0]    rd_index,
    output logic [NUM_CH*COLOR_W-1:0]    red,
    output logic [NUM_CH*COLOR_W-1:0]    green,
    output logic [NUM_CH*COLOR_W-1:0]    blue,
    output logic [NUM_CH-1:0]            transparent,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic                         step_tick,
    input  logic                         fade_start,
    input  logic                         fade_dir,
    output logic                         fade_busy,
    output logic [COLOR_W-1:0]           fade_level
);
    localparam int DEPTH = 2**INDEX_W;
    localparam int RGB_W = 3*COLOR_W;
    localparam int MUL_W = 2*COLOR_W+1;
    localparam logic [COLOR_W-1:0] LVL_MAX = '1;
    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;
    logic [RGB_W-1:0] mem_q [DEPTH];
    logic [RGB_W-1:0] lut_rgb [NUM_CH];
    logic [NUM_CH*COLOR_W-1:0] red_q, green_q, blue_q;
    logic [NUM_CH-1:0] key_q, valid_q;
    state_t state_q, state_d;
    logic [COLOR_W-1:0] level_q, level_d;
    logic busy_q;

    function automatic logic [COLOR_W-1:0] fade(input logic [COLOR_W-1:0] comp, input logic [COLOR_W-1:0] lvl);
        logic [MUL_W-1:0] p;
        p = MUL_W'(comp) * (MUL_W'(lvl) + MUL_W'(1));
        return COLOR_W'(p >> COLOR_W);
    endfunction

    // palette storage: grey ramp on reset, one entry written per cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= {3{COLOR_W'(i)}};
        end else if (wr_en) begin
            mem_q[wr_index] <= wr_rgb;
        end
    end

    // lookup per channel with write-first bypass so a same-cycle write is seen
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            lut_rgb[c] = (wr_en && wr_index == rd_index[c*INDEX_W +: INDEX_W]) ? wr_rgb
                         : mem_q[rd_index[c*INDEX_W +: INDEX_W]];
        end
    end

    // registered faded colour and key flag; idle channels hold their last colour
    always_ff @(posedge Clk) begin
        if (Reset) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            key_q   <= '0;
            valid_q <= '0;
        end else begin
            valid_q <= rd_req;
            for (int c = 0; c < NUM_CH; c++) begin
                if (rd_req[c]) begin
                    red_q[c*COLOR_W +: COLOR_W]   <= fade(lut_rgb[c][RGB_W-1 -: COLOR_W], level_q);
                    green_q[c*COLOR_W +: COLOR_W] <= fade(lut_rgb[c][2*COLOR_W-1 -: COLOR_W], level_q);
                    blue_q[c*COLOR_W +: COLOR_W]  <= fade(lut_rgb[c][COLOR_W-1:0], level_q);
                    key_q[c] <= rd_index[c*INDEX_W +: INDEX_W] == INDEX_W'(KEY_INDEX);
                end
            end
        end
    end

    // fade engine: one level step per tick, back to idle once the target level is reached
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        unique case (state_q)
            IDLE:     if (fade_start) state_d = fade_dir ? FADE_IN : FADE_OUT;
            FADE_OUT: begin
                if (level_q == '0) state_d = IDLE;
                else if (step_tick) begin
                    level_d = level_q - 1'b1;
                    state_d = (level_q == COLOR_W'(1)) ? IDLE : FADE_OUT;
                end
            end
            FADE_IN: begin
                if (level_q == LVL_MAX) state_d = IDLE;
                else if (step_tick) begin
                    level_d = level_q + 1'b1;
                    state_d = (level_q == LVL_MAX - 1'b1) ? IDLE : FADE_IN;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // fade state, level and busy flag registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            level_q <= LVL_MAX;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            busy_q  <= state_d != IDLE;
        end
    end

    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign transparent = key_q;
    assign out_valid   = valid_q;
    assign fade_busy   = busy_q;
    assign fade_level  = level_q;
endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: directed scoreboard bench for palette_lut
module tb_palette_lut;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_index = '0;
    logic [11:0] wr_rgb = '0;
    logic [1:0]  rd_req = '0;
    logic [7:0]  rd_index = '0;
    logic [7:0]  red, green, blue;
    logic [1:0]  transparent, out_valid;
    logic        step_tick = 1'b0;
    logic        fade_start = 1'b0;
    logic        fade_dir = 1'b0;
    logic        fade_busy;
    logic [3:0]  fade_level;
    logic [12:0] q0[$];
    logic [12:0] q1[$];
    int total = 0;
    int bad = 0;

    palette_lut dut (
        .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_index(wr_index), .wr_rgb(wr_rgb),
        .rd_req(rd_req), .rd_index(rd_index), .red(red), .green(green), .blue(blue),
        .transparent(transparent), .out_valid(out_valid), .step_tick(step_tick),
        .fade_start(fade_start), .fade_dir(fade_dir), .fade_busy(fade_busy), .fade_level(fade_level)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic rd(input int c, input logic [3:0] idx, input logic [11:0] e, input logic t);
        rd_req[c] = 1'b1;
        rd_index[c*4 +: 4] = idx;
        if (c == 0) q0.push_back({t, e});
        else q1.push_back({t, e});
    endtask

    task automatic wr(input logic [3:0] idx, input logic [11:0] d);
        wr_en = 1'b1;
        wr_index = idx;
        wr_rgb = d;
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
        rd_req = '0;
        wr_en = 1'b0;
        fade_start = 1'b0;
        step_tick = 1'b0;
    endtask

    // monitor: pop expected response whenever a channel presents valid output
    initial begin
        logic [12:0] got, exp;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                for (int c = 0; c < 2; c++) begin
                    if (out_valid[c]) begin
                        got = {transparent[c], red[c*4 +: 4], green[c*4 +: 4], blue[c*4 +: 4]};
                        if (c == 0 && q0.size() == 0 || c == 1 && q1.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL ch%0d unexpected valid got=%h", c, got);
                        end else begin
                            exp = (c == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("ch%0d_read", c), 32'(got), 32'(exp));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("rst_rgb", 32'({red, green, blue}), 32'(0));
        chk("rst_valid", 32'({transparent, out_valid}), 32'(0));
        chk("rst_level", 32'(fade_level), 32'(15));
        chk("rst_busy", 32'(fade_busy), 32'(0));
        rd(0, 4'd9, 12'h999, 1'b0);
        rd(1, 4'd5, 12'h555, 1'b1);
        cyc();
        wr(4'd3, 12'hA62);
        cyc();
        rd(0, 4'd3, 12'hA62, 1'b0);
        cyc();
        wr(4'd7, 12'hD94);
        rd(0, 4'd7, 12'hD94, 1'b0);
        cyc();
        wr(4'd10, 12'h123);
        rd(0, 4'd10, 12'h123, 1'b0);
        rd(1, 4'd10, 12'h123, 1'b0);
        cyc();
        rd(1, 4'd7, 12'hD94, 1'b0);
        cyc();
        fade_start = 1'b1;
        fade_dir = 1'b0;
        rd(0, 4'd3, 12'hA62, 1'b0);
        cyc();
        for (int k = 1; k <= 15; k++) begin
            step_tick = 1'b1;
            cyc();
            chk("fo_level", 32'(fade_level), 32'(15 - k));
            if (k < 15) chk("fo_busy", 32'(fade_busy), 32'(1));
            if (k == 8) begin
                rd(0, 4'd3, 12'h531, 1'b0);
                rd(1, 4'd7, 12'h642, 1'b0);
                cyc();
            end
        end
        cyc();
        cyc();
        chk("fo_done_busy", 32'(fade_busy), 32'(0));
        chk("fo_done_level", 32'(fade_level), 32'(0));
        rd(0, 4'd3, 12'h000, 1'b0);
        rd(1, 4'd5, 12'h000, 1'b1);
        cyc();
        fade_start = 1'b1;
        fade_dir = 1'b1;
        cyc();
        for (int k = 1; k <= 15; k++) begin
            step_tick = 1'b1;
            if (k == 5) begin
                fade_start = 1'b1;
                fade_dir = 1'b0;
            end
            cyc();
            chk("fi_level", 32'(fade_level), 32'(k));
        end
        cyc();
        cyc();
        chk("fi_done_busy", 32'(fade_busy), 32'(0));
        chk("fi_done_level", 32'(fade_level), 32'(15));
        rd(0, 4'd3, 12'hA62, 1'b0);
        cyc();
        fade_start = 1'b1;
        fade_dir = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("at_target_level", 32'(fade_level), 32'(15));
        chk("at_target_busy", 32'(fade_busy), 32'(0));
        step_tick = 1'b1;
        cyc();
        chk("idle_tick_level", 32'(fade_level), 32'(15));
        fade_start = 1'b1;
        fade_dir = 1'b0;
        cyc();
        repeat (7) begin
            step_tick = 1'b1;
            cyc();
        end
        chk("mid_level", 32'(fade_level), 32'(8));
        chk("mid_busy", 32'(fade_busy), 32'(1));
        Reset = 1'b1;
        wr(4'd2, 12'hFFF);
        fade_start = 1'b1;
        fade_dir = 1'b0;
        cyc();
        Reset = 1'b0;
        chk("rst_mid_level", 32'(fade_level), 32'(15));
        chk("rst_mid_busy", 32'(fade_busy), 32'(0));
        cyc();
        chk("rst_start_ignored", 32'(fade_busy), 32'(0));
        rd(0, 4'd2, 12'h222, 1'b0);
        cyc();
        rd(0, 4'd1, 12'h111, 1'b0);
        rd(1, 4'd4, 12'h444, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            rd(0, 4'(6 + i), 12'(12'h111 * (6 + i)), 1'b0);
            cyc();
            chk("hold_rgb1", 32'({red[7:4], green[7:4], blue[7:4]}), 32'(12'h444));
            chk("hold_valid1", 32'(out_valid[1]), 32'(0));
        end
        rd(1, 4'd15, 12'hFFF, 1'b0);
        rd(0, 4'd0, 12'h000, 1'b0);
        cyc();
        cyc();
        cyc();
        chk("sb_drain", 32'(q0.size() + q1.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
